// File: rtl/alu_core_param.sv
// Two-operand ALU with load/exec pulses; one-cycle ops, optional WIDTH-cycle MUL/DIV (define ALU_MULDIV_EN).
// Latency: 1 cycle for simple ops, WIDTH cycles for MUL/DIV; pulses are dropped while busy.
module alu_core_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_a,
    input  logic             ld_b,
    input  logic             exec,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [3:0]       flags,
    output logic [3:0]       tag,
    output logic             busy,
    output logic             done,
    output logic             dz
);

    logic [WIDTH-1:0] a, b;
    logic [3:0]       op;
    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;
    logic             nxt_c, nxt_v, op_valid, div_zero, start_mc, idle;
    logic [3:0]       nxt_flags;

    assign op = sw[3:0];

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} - {1'b0, b};
        nxt_hi   = '0;
        nxt_lo   = '0;
        nxt_c    = 1'b0;
        nxt_v    = 1'b0;
        op_valid = 1'b1;
        div_zero = 1'b0;
        start_mc = 1'b0;
        case (op)
            4'd1: begin
                nxt_lo    = sum[WIDTH-1:0];
                nxt_hi[0] = sum[WIDTH];
                nxt_c     = sum[WIDTH];
                nxt_v     = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd2: begin
                // diff[WIDTH] is the borrow out of the zero-extended subtraction
                nxt_lo = diff[WIDTH-1:0];
                nxt_c  = diff[WIDTH];
                nxt_v  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            4'd3: nxt_lo = ~a;
            4'd4: nxt_lo = a & b;
            4'd5: nxt_lo = a | b;
            4'd6: nxt_lo = a ^ b;
            4'd9: begin
                nxt_lo = {a[WIDTH-2:0], 1'b0};
                nxt_c  = a[WIDTH-1];
            end
            4'd10: begin
                nxt_lo = {1'b0, a[WIDTH-1:1]};
                nxt_c  = a[0];
            end
`ifdef ALU_MULDIV_EN
            4'd7: start_mc = 1'b1;
            4'd8: begin
                if (b == '0) begin
                    div_zero = 1'b1;
                    nxt_lo   = '1;
                    nxt_hi   = a;
                end else begin
                    start_mc = 1'b1;
                end
            end
`endif
            default: op_valid = 1'b0;
        endcase
        nxt_flags = op_valid ? {nxt_lo[WIDTH-1], nxt_lo == '0, nxt_c, nxt_v} : 4'b0000;
    end

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
    state_t           state;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] wk_hi, wk_lo, opnd, step_hi, step_lo;
    logic [WIDTH:0]   msum, rem_sh, trial;

    assign idle = (state == S_IDLE);

    // MUL: wk_lo holds the multiplier shifting out; DIV: wk_hi is the remainder, wk_lo the quotient
    always_comb begin
        msum   = {1'b0, wk_hi} + (wk_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh = {wk_hi, wk_lo[WIDTH-1]};
        trial  = rem_sh - {1'b0, opnd};
        if (state == S_DIV) begin
            step_hi = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            step_lo = {wk_lo[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            step_hi = msum[WIDTH:1];
            step_lo = {msum[0], wk_lo[WIDTH-1:1]};
        end
    end
`else
    assign idle = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            res_hi <= '0;
            res_lo <= '0;
            flags  <= '0;
            tag    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            dz     <= 1'b0;
`ifdef ALU_MULDIV_EN
            state  <= S_IDLE;
            cnt    <= '0;
            wk_hi  <= '0;
            wk_lo  <= '0;
            opnd   <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (idle) begin
                if (ld_a) begin
                    a      <= sw;
                    res_lo <= sw;
                    res_hi <= '0;
                    flags  <= '0;
                    tag    <= 4'hA;
                end else if (ld_b) begin
                    b      <= sw;
                    res_lo <= sw;
                    res_hi <= '0;
                    flags  <= '0;
                    tag    <= 4'hB;
                end else if (exec) begin
                    tag <= 4'hC;
                    dz  <= div_zero;
                    if (start_mc) begin
`ifdef ALU_MULDIV_EN
                        busy  <= 1'b1;
                        cnt   <= '0;
                        wk_hi <= '0;
                        if (op == 4'd7) begin
                            state <= S_MUL;
                            wk_lo <= b;
                            opnd  <= a;
                        end else begin
                            state <= S_DIV;
                            wk_lo <= a;
                            opnd  <= b;
                        end
`endif
                    end else begin
                        res_hi <= nxt_hi;
                        res_lo <= nxt_lo;
                        flags  <= nxt_flags;
                        done   <= 1'b1;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            else begin
                wk_hi <= step_hi;
                wk_lo <= step_lo;
                cnt   <= cnt + 6'd1;
                if (cnt == 6'(WIDTH-1)) begin
                    res_hi <= step_hi;
                    res_lo <= step_lo;
                    flags  <= (state == S_MUL)
                            ? {step_lo[WIDTH-1], step_lo == '0, step_hi != '0, step_hi != '0}
                            : {step_lo[WIDTH-1], step_lo == '0, 2'b00};
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= S_IDLE;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_core_param.sv
// Directed bench for alu_core_param at WIDTH=8; MUL/DIV scenarios run only when ALU_MULDIV_EN is defined.
module tb_alu_core_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld_a = 1'b0, ld_b = 1'b0, exec = 1'b0;
    logic [7:0] sw = 8'h00;
    logic [7:0] res_hi, res_lo;
    logic [3:0] flags, tag;
    logic       busy, done, dz;

    int errors = 0;
    int checks = 0;

    alu_core_param #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ld_a(ld_a), .ld_b(ld_b), .exec(exec), .sw(sw),
        .res_hi(res_hi), .res_lo(res_lo), .flags(flags), .tag(tag),
        .busy(busy), .done(done), .dz(dz)
    );

    always #5 clk = ~clk;

    // kind: 0 ld_a, 1 ld_b, 2 exec; returns at the negedge after the accepting edge
    task automatic pulse(input int kind, input logic [7:0] v);
        @(negedge clk);
        sw   = v;
        ld_a = (kind == 0);
        ld_b = (kind == 1);
        exec = (kind == 2);
        @(negedge clk);
        ld_a = 1'b0;
        ld_b = 1'b0;
        exec = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++; if ({res_hi, res_lo} !== 16'h0) begin errors++; $display("FAIL reset_res got=%h exp=0000", {res_hi, res_lo}); end
        checks++; if ({flags, tag} !== 8'h00) begin errors++; $display("FAIL reset_flags_tag got=%h exp=00", {flags, tag}); end
        checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL reset_ctl got=%b exp=000", {busy, done, dz}); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        pulse(0, 8'hC8);
        checks++; if ({res_hi, res_lo, tag, done} !== {8'h00, 8'hC8, 4'hA, 1'b0}) begin errors++; $display("FAIL ld_a got=%h/%h/%h/%b exp=00/c8/a/0", res_hi, res_lo, tag, done); end
        pulse(1, 8'h64);
        checks++; if ({res_lo, tag, flags} !== {8'h64, 4'hB, 4'h0}) begin errors++; $display("FAIL ld_b got=%h/%h/%b exp=64/b/0000", res_lo, tag, flags); end
        pulse(2, 8'h01);
        checks++; if ({res_hi, res_lo} !== 16'h012C) begin errors++; $display("FAIL add_res got=%h exp=012c", {res_hi, res_lo}); end
        checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL add_flags got=%b exp=0010", flags); end
        checks++; if ({tag, done, busy} !== {4'hC, 1'b1, 1'b0}) begin errors++; $display("FAIL add_tag_done got=%h/%b/%b exp=c/1/0", tag, done, busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_width got=%b exp=0", done); end
        pulse(0, 8'h7F);
        pulse(1, 8'h01);
        pulse(2, 8'h01);
        checks++; if ({res_hi, res_lo, flags} !== {8'h00, 8'h80, 4'b1001}) begin errors++; $display("FAIL add_ovf got=%h/%h/%b exp=00/80/1001", res_hi, res_lo, flags); end
    endtask

    task automatic test_sub_xor;
        pulse(0, 8'h05);
        pulse(1, 8'h07);
        pulse(2, 8'h02);
        checks++; if ({res_hi, res_lo, flags} !== {8'h00, 8'hFE, 4'b1010}) begin errors++; $display("FAIL sub got=%h/%h/%b exp=00/fe/1010", res_hi, res_lo, flags); end
        pulse(0, 8'h5A);
        pulse(1, 8'h5A);
        pulse(2, 8'h06);
        checks++; if ({res_lo, flags} !== {8'h00, 4'b0100}) begin errors++; $display("FAIL xor_zero got=%h/%b exp=00/0100", res_lo, flags); end
    endtask

    task automatic test_logic_shift;
        logic [3:0] ops   [5] = '{4'd3, 4'd4, 4'd5, 4'd9, 4'd10};
        logic [7:0] exp_r [5] = '{8'h7E, 8'h00, 8'hBD, 8'h02, 8'h40};
        logic [3:0] exp_f [5] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0010};
        pulse(0, 8'h81);
        pulse(1, 8'h3C);
        for (int i = 0; i < 5; i++) begin
            pulse(2, {4'h0, ops[i]});
            checks++;
            if ({res_hi, res_lo, flags} !== {8'h00, exp_r[i], exp_f[i]}) begin
                errors++;
                $display("FAIL logic_op%0d got=%h/%h/%b exp=00/%h/%b", ops[i], res_hi, res_lo, flags, exp_r[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_priority;
        @(negedge clk);
        sw = 8'h23; ld_a = 1'b1; exec = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; exec = 1'b0;
        checks++; if ({res_lo, tag, done} !== {8'h23, 4'hA, 1'b0}) begin errors++; $display("FAIL prio_lda_exec got=%h/%h/%b exp=23/a/0", res_lo, tag, done); end
        pulse(2, 8'h03);
        checks++; if ({res_lo, flags} !== {8'hDC, 4'b1000}) begin errors++; $display("FAIL prio_a_loaded got=%h/%b exp=dc/1000", res_lo, flags); end
    endtask

    task automatic test_invalid;
`ifdef ALU_MULDIV_EN
        logic [3:0] ops [3] = '{4'd0, 4'd11, 4'd15};
        int n = 3;
`else
        logic [3:0] ops [5] = '{4'd7, 4'd8, 4'd0, 4'd11, 4'd15};
        int n = 5;
`endif
        pulse(1, 8'h03);
        for (int i = 0; i < n; i++) begin
            pulse(0, 8'h55);
            pulse(2, {4'h0, ops[i]});
            checks++;
            if ({res_hi, res_lo, flags, tag, busy, done, dz} !== {8'h00, 8'h00, 4'h0, 4'hC, 3'b010}) begin
                errors++;
                $display("FAIL invalid_op%0d got=%h/%h/%b/%h/%b%b%b exp=00/00/0000/c/010", ops[i], res_hi, res_lo, flags, tag, busy, done, dz);
            end
        end
    endtask

    task automatic test_hold;
        pulse(0, 8'h12);
        pulse(1, 8'h34);
        pulse(2, 8'h05);
        repeat (4) @(negedge clk);
        checks++; if ({res_hi, res_lo, flags, tag, done} !== {8'h00, 8'h36, 4'h0, 4'hC, 1'b0}) begin errors++; $display("FAIL hold got=%h/%h/%b/%h/%b exp=00/36/0000/c/0", res_hi, res_lo, flags, tag, done); end
    endtask

    task automatic test_reset_mid;
`ifdef ALU_MULDIV_EN
        pulse(0, 8'hFF);
        pulse(1, 8'hFF);
        pulse(2, 8'h07);
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy); end
`else
        pulse(0, 8'h33);
`endif
        rst = 1'b1;
        #1;
        checks++; if ({res_hi, res_lo, flags, tag} !== 24'h0) begin errors++; $display("FAIL mid_rst_out got=%h/%h/%b/%h exp=00/00/0000/0", res_hi, res_lo, flags, tag); end
        checks++; if ({busy, done, dz} !== 3'b000) begin errors++; $display("FAIL mid_rst_ctl got=%b exp=000", {busy, done, dz}); end
        @(negedge clk);
        sw = 8'h44; ld_a = 1'b1;
        @(negedge clk);
        ld_a = 1'b0; rst = 1'b0;
        checks++; if ({res_lo, tag} !== 12'h000) begin errors++; $display("FAIL rst_ignores_ld got=%h/%h exp=00/0", res_lo, tag); end
        pulse(1, 8'h09);
        pulse(2, 8'h01);
        checks++; if ({res_hi, res_lo, flags, tag, done, busy} !== {8'h00, 8'h09, 4'h0, 4'hC, 2'b10}) begin errors++; $display("FAIL post_rst_add got=%h/%h/%b/%h/%b%b exp=00/09/0000/c/10", res_hi, res_lo, flags, tag, done, busy); end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_mul;
        int cnt = 0;
        pulse(0, 8'hFF);
        pulse(1, 8'hFF);
        pulse(2, 8'h07);
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            cnt++;
            ld_a = (cnt == 2);
            sw   = (cnt == 2) ? 8'h11 : 8'hA7;
            if (cnt == 4) begin
                checks++; if ({res_hi, res_lo, done} !== {8'h00, 8'hFF, 1'b0}) begin errors++; $display("FAIL mul_hold got=%h/%h/%b exp=00/ff/0", res_hi, res_lo, done); end
            end
            @(negedge clk);
        end
        ld_a = 1'b0;
        checks++; if (cnt !== 8) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=8", cnt); end
        checks++; if ({res_hi, res_lo, flags, done} !== {16'hFE01, 4'b0011, 1'b1}) begin errors++; $display("FAIL mul_res got=%h%h/%b/%b exp=fe01/0011/1", res_hi, res_lo, flags, done); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mul_done_width got=%b exp=0", done); end
        pulse(2, 8'h03);
        checks++; if (res_lo !== 8'h00) begin errors++; $display("FAIL mul_lda_ignored got=%h exp=00", res_lo); end
    endtask

    task automatic test_div;
        int cnt = 0;
        pulse(0, 8'd200);
        pulse(1, 8'd7);
        pulse(2, 8'h08);
        for (int i = 0; i < 40 && busy === 1'b1; i++) begin
            cnt++;
            @(negedge clk);
        end
        checks++; if (cnt !== 8) begin errors++; $display("FAIL div_busy_cycles got=%0d exp=8", cnt); end
        checks++; if ({res_hi, res_lo, flags, done, dz} !== {8'd4, 8'd28, 4'b0000, 2'b10}) begin errors++; $display("FAIL div_res got=%h/%h/%b/%b%b exp=04/1c/0000/10", res_hi, res_lo, flags, done, dz); end
        pulse(1, 8'h00);
        pulse(2, 8'h08);
        checks++; if ({res_hi, res_lo, flags, busy, done, dz} !== {8'd200, 8'hFF, 4'b1000, 3'b011}) begin errors++; $display("FAIL div_zero got=%h/%h/%b/%b%b%b exp=c8/ff/1000/011", res_hi, res_lo, flags, busy, done, dz); end
        repeat (2) @(negedge clk);
        checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_sticky got=%b exp=1", dz); end
        pulse(2, 8'h01);
        checks++; if ({res_lo, dz} !== {8'd200, 1'b0}) begin errors++; $display("FAIL dz_clear got=%h/%b exp=c8/0", res_lo, dz); end
    endtask
`endif

    initial begin
        test_reset;
        test_add;
        test_sub_xor;
        test_logic_shift;
        test_priority;
        test_invalid;
        test_hold;
`ifdef ALU_MULDIV_EN
        test_mul;
        test_div;
`endif
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_core_param.md
ALU_CORE_PARAM -- requirements
Module: alu_core_param

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result-half width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ld_a  input  1  one-cycle pulse, load operand A from sw.
REQ-005 SHALL have port ld_b  input  1  one-cycle pulse, load operand B from sw.
REQ-006 SHALL have port exec  input  1  one-cycle pulse, start operation with opcode sw[3:0].
REQ-007 SHALL have port sw  input  WIDTH  operand data / opcode source.
REQ-008 SHALL have port res_hi  output  WIDTH  upper result half (carry, product high, remainder).
REQ-009 SHALL have port res_lo  output  WIDTH  lower result half (sum, product low, quotient).
REQ-010 SHALL have port flags  output  4  {N, Z, C, V} of last completed operation.
REQ-011 SHALL have port tag  output  4  display letter code: 0 reset, 4'hA A loaded, 4'hB B loaded, 4'hC result.
REQ-012 SHALL have ports busy, done, dz  output  1 each  multi-cycle in progress / one-cycle completion pulse / divide-by-zero sticky.

Function
REQ-013 SHALL accept ld_a, ld_b, exec only in IDLE, priority ld_a > ld_b > exec on the same edge; lower-priority pulses that edge are dropped.
REQ-014 SHALL on ld_a: A<=sw, res_lo<=sw, res_hi<=0, flags<=0, tag<=4'hA; ld_b likewise with B, tag<=4'hB; done not asserted.
REQ-015 SHALL on exec set tag<=4'hC and decode sw[3:0]: 1 A+B, 2 A-B, 3 ~A, 4 A&B, 5 A|B, 6 A^B, 7 A*B, 8 A/B, 9 A<<1, 10 A>>1 (logical); any other code: res_hi=res_lo=0, flags=0.
REQ-016 SHALL complete opcodes other than 7/8 in one cycle: result and flags registered on the exec edge, done high the following cycle for exactly one cycle, busy stays 0.
REQ-017 SHALL compute add as {res_hi,res_lo}={0..,carry,sum}, C=carry out, V=signed overflow; sub as res_lo=A-B mod 2^WIDTH, C=borrow (A<B unsigned), V=signed overflow, res_hi=0.
REQ-018 SHALL for shifts set C to the bit shifted out, res_hi=0; logic ops C=V=0, res_hi=0.
REQ-019 SHALL set Z=1 iff res_lo==0 and N=res_lo[WIDTH-1] for every executed opcode.
REQ-020 SHALL implement state machine IDLE -> MUL (op 7) or DIV (op 8) -> IDLE; MUL/DIV run exactly WIDTH iteration cycles with busy=1.
REQ-021 SHALL implement MUL as unsigned shift-add, full 2*WIDTH-bit product into {res_hi,res_lo}; C=V=(res_hi!=0).
REQ-022 SHALL implement DIV as unsigned restoring division: res_lo=quotient, res_hi=remainder, C=V=0.
REQ-023 SHALL on DIV with B==0 skip iteration: res_lo=all ones, res_hi=A, dz<=1, result and done as single-cycle op; dz cleared only by reset or next successful exec.
REQ-024 SHALL keep res_hi/res_lo/flags unchanged during MUL/DIV iterations and update them on the final iteration edge; done pulses the cycle after, with busy deasserted on that same edge.
REQ-025 SHALL latch operands at exec; sw changes during busy do not affect the result.
REQ-026 SHALL hold all outputs between events (no decay to zero when inputs idle).

Reset
REQ-027 SHALL on rst asynchronously force state IDLE, A=B=0, res_hi=0, res_lo=0, flags=0, tag=0, busy=0, done=0, dz=0, including mid-MUL/DIV (partial result discarded).
REQ-028 SHALL ignore ld_a/ld_b/exec while rst is high; first accepted pulse is on the first edge after rst release.

Configuration
REQ-029 SHALL compile MUL/DIV datapath and states only when macro ALU_MULDIV_EN is defined.
REQ-030 SHALL, without ALU_MULDIV_EN, treat opcodes 7 and 8 as invalid (zero result, flags 0), never assert busy or dz.

Verification (WIDTH=8)
REQ-031 SHALL check: ld_a sw=8'hC8, ld_b sw=8'h64, exec sw=1 -> res_hi=1, res_lo=8'h2C, C=1, Z=0, tag=4'hC, done one cycle.
REQ-032 SHALL check: A=8'h05, B=8'h07, exec op 2 -> res_lo=8'hFE, C=1, N=1; exec op 6 with A=B=8'h5A -> res_lo=0, Z=1.
REQ-033 SHALL check (macro on): A=8'hFF, B=8'hFF, exec op 7 -> busy 8 cycles, {res_hi,res_lo}=16'hFE01, C=1, done once; ld_a pulse during busy ignored.
REQ-034 SHALL check (macro on): A=8'd200, B=8'd7, op 8 -> res_lo=28, res_hi=4; B=0 -> res_lo=8'hFF, res_hi=8'd200, dz=1, busy never asserted.
REQ-035 SHALL check: rst asserted 3 cycles into MUL -> all outputs 0 immediately, IDLE, next exec op 1 completes in one cycle.
REQ-036 SHALL check: ld_a and exec same edge -> only A loaded, tag=4'hA; macro off, op 7 -> result 0, busy stays 0.
